// File: rtl/prod_accum_pkg.sv
// Shared widths, FSM state encoding and signed data types for the product accumulator.
package prod_accum_pkg;

  localparam int PROD_W = 28;
  localparam int ACC_W  = 36;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/prod_accum_1612_accum_add.sv
// Combinational signed adder with overflow detect; PROD_ACCUM_SAT_EN selects clamping
// instead of two's-complement wrap on overflow.
module accum_add #(
  parameter int ACC_W = 36
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] raw_sum;

  assign raw_sum = a + b;
  // Overflow only possible when both operands share a sign that the result lacks.
  assign ovf     = (a[ACC_W-1] == b[ACC_W-1]) && (raw_sum[ACC_W-1] != a[ACC_W-1]);

`ifdef PROD_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // The true result carries the operands' common sign.
  assign sum = ovf ? (a[ACC_W-1] ? NEG_MIN : POS_MAX) : raw_sum;
`else
  assign sum = raw_sum;
`endif

endmodule

// File: rtl/prod_accum_1612.sv
// Group accumulator for 28-bit signed products with a valid/ready result port.
// Optional macro PROD_ACCUM_SAT_EN: saturate the accumulator instead of wrapping.
module prod_accum_1612 #(
  parameter int PROD_W = prod_accum_pkg::PROD_W,
  parameter int ACC_W  = prod_accum_pkg::ACC_W,
  parameter int CNT_W  = prod_accum_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  import prod_accum_pkg::*;

  acc_state_t        state_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;

  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  add_sum;
  logic              add_ovf;
  logic              beat;
  logic              hold;

  assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

  accum_add #(.ACC_W(ACC_W)) u_add (
    .a   (acc_reg),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign hold      = (state_reg == HOLD);
  assign in_ready  = !hold;
  assign beat      = in_valid && in_ready;

  assign out_valid = hold;
  assign out_sum   = hold ? acc_reg : '0;
  assign out_count = hold ? cnt_reg : '0;
  assign out_ovf   = hold && ovf_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (beat) begin
            acc_reg   <= prod_ext;
            cnt_reg   <= {{(CNT_W-1){1'b0}}, 1'b1};
            ovf_reg   <= 1'b0;
            state_reg <= in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_reg   <= add_sum;
            // Term count saturates silently; it never feeds the overflow flag.
            cnt_reg   <= (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
            ovf_reg   <= ovf_reg | add_ovf;
            state_reg <= in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          acc_reg   <= '0;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accum_1612.sv
// Self-checking bench for prod_accum_1612: fixed vectors, corner sequences and
// randomized groups checked against an arithmetic reference model.
module tb_prod_accum_1612;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_prod;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  logic [27:0] gp [0:1023];
  int          gn;

  localparam longint ACC_MAX = 64'sd34359738367;   // 2^35 - 1
  localparam longint ACC_MIN = -64'sd34359738368;  // -2^35
  localparam longint ACC_MOD = 64'sd68719476736;   // 2^36

  typedef struct {
    int          n;
    logic [27:0] p0, p1, p2;
    logic [35:0] es;
    logic [7:0]  ec;
    logic        eo;
    int          hold;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  prod_accum_1612 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum the group with plain integer arithmetic, checking range after each add.
  task automatic model(output logic [35:0] s, output logic [7:0] c, output logic o);
    longint acc;
    longint p;
    longint t;
    acc = 0;
    o   = 1'b0;
    for (int i = 0; i < gn; i++) begin
      p = longint'($signed(gp[i]));
      if (i == 0) begin
        acc = p;
      end else begin
        t = acc + p;
        if (t > ACC_MAX || t < ACC_MIN) begin
          o = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
          acc = (t > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
          acc = (t > ACC_MAX) ? t - ACC_MOD : t + ACC_MOD;
`endif
        end else begin
          acc = t;
        end
      end
    end
    s = acc[35:0];
    c = (gn > 255) ? 8'hFF : gn[7:0];
  endtask

  // Feed gp[0..gn-1]; bubbles carry junk that must be ignored.
  task automatic send_beats(input int bubbles_max, input bit mark_last);
    int w;
    for (int i = 0; i < gn; i++) begin
      repeat ($urandom_range(0, bubbles_max)) begin
        in_valid = 1'b0;
        in_prod  = 28'($urandom);
        in_last  = 1'b1;
        tick();
      end
      in_valid = 1'b1;
      in_prod  = gp[i];
      in_last  = mark_last && (i == gn - 1);
      w = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one cycle after the last beat: result must already be valid.
  task automatic finish_group(input string nm, input logic [35:0] es, input logic [7:0] ec,
                              input logic eo, input int hold);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_sum"},   64'(out_sum),   64'(es));
    chk({nm, "_count"}, 64'(out_count), 64'(ec));
    chk({nm, "_ovf"},   64'(out_ovf),   64'(eo));
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_prod  = 28'($urandom);
      in_last  = 1'($urandom);
      tick();
      chk({nm, "_bp_ready"}, 64'(in_ready),  64'd0);
      chk({nm, "_bp_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_bp_sum"},   64'(out_sum),   64'(es));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_idle_ready"}, 64'(in_ready),  64'd1);
    chk({nm, "_idle_sum"},   64'(out_sum),   64'd0);
    $display("group %s: n=%0d sum=%h count=%0d ovf=%0d hold=%0d", nm, gn, es, ec, eo, hold);
  endtask

  initial begin
    logic [35:0] es;
    logic [7:0]  ec;
    logic        eo;
    bit          neg;
    int          pick;

    tbl[0] = '{n:1, p0:28'hFFFFFF6, p1:28'h0, p2:28'h0, es:36'hFFFFFFFF6, ec:8'd1, eo:1'b0, hold:0};
    tbl[1] = '{n:3, p0:28'h0000064, p1:28'hFFFFFF6, p2:28'h4000000, es:36'h00400005A, ec:8'd3, eo:1'b0, hold:0};
    tbl[2] = '{n:1, p0:28'h0000123, p1:28'h0, p2:28'h0, es:36'h000000123, ec:8'd1, eo:1'b0, hold:5};
    tbl[3] = '{n:1, p0:28'h7FFFFFF, p1:28'h0, p2:28'h0, es:36'h007FFFFFF, ec:8'd1, eo:1'b0, hold:1};
    tbl[4] = '{n:1, p0:28'h8000000, p1:28'h0, p2:28'h0, es:36'hFF8000000, ec:8'd1, eo:1'b0, hold:0};
    tbl[5] = '{n:2, p0:28'h7FFFFFF, p1:28'h7FFFFFF, p2:28'h0, es:36'h00FFFFFFE, ec:8'd2, eo:1'b0, hold:2};

    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_prod   = 28'h0000005;
    in_last   = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    chk("rst_sum",   64'(out_sum),   64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    $display("reset held 2 cycles with in_valid=1");
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("rst_no_beat", 64'(out_valid), 64'd0);

    for (int v = 0; v < 6; v++) begin
      gn    = tbl[v].n;
      gp[0] = tbl[v].p0;
      gp[1] = tbl[v].p1;
      gp[2] = tbl[v].p2;
      send_beats(0, 1'b1);
      finish_group($sformatf("vec%0d", v), tbl[v].es, tbl[v].ec, tbl[v].eo, tbl[v].hold);
    end

    // Reset in the middle of a group discards the partial sum.
    gn    = 2;
    gp[0] = 28'h0000010;
    gp[1] = 28'h0000010;
    send_beats(0, 1'b0);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_prod  = 28'h0000007;
    in_last  = 1'b1;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(in_ready),  64'd1);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    gn    = 1;
    gp[0] = 28'h0000005;
    send_beats(0, 1'b1);
    finish_group("midrst", 36'h000000005, 8'd1, 1'b0, 0);

    // 512 x 2^26 = 2^35 overflows on the final add; count saturates.
    gn = 512;
    for (int i = 0; i < 512; i++) gp[i] = 28'h4000000;
    send_beats(0, 1'b1);
`ifdef PROD_ACCUM_SAT_EN
    finish_group("ovf512", 36'h7FFFFFFFF, 8'hFF, 1'b1, 1);
`else
    finish_group("ovf512", 36'h800000000, 8'hFF, 1'b1, 1);
`endif

    for (int g = 0; g < 40; g++) begin
      if (g % 10 == 9) begin
        gn  = $urandom_range(280, 400);
        neg = 1'($urandom);
        for (int i = 0; i < gn; i++) begin
          gp[i] = neg ? 28'($urandom_range(28'h8000000, 28'hA000000))
                      : 28'($urandom_range(28'h6000000, 28'h7FFFFFF));
        end
      end else begin
        gn = $urandom_range(1, 6);
        for (int i = 0; i < gn; i++) begin
          pick = $urandom_range(0, 3);
          case (pick)
            0:       gp[i] = 28'($urandom);
            1:       gp[i] = 28'h7FFFFFF;
            2:       gp[i] = 28'h8000000;
            default: gp[i] = 28'($urandom_range(0, 255));
          endcase
        end
      end
      model(es, ec, eo);
      send_beats(2, 1'b1);
      finish_group($sformatf("rnd%0d", g), es, ec, eo, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
